// File: rtl/cache_pkg.sv
// Shared cache-path defaults and helpers, also used by the refill engine.
package cache_pkg;

    localparam int unsigned ENTRIES_DEF     = 4;
    localparam int unsigned PA_WIDTH_DEF    = 64;
    localparam int unsigned OFFSET_BITS_DEF = 6;
    localparam int unsigned CNT_WIDTH_DEF   = 12;

    // Replacement priority class; lower value wins the victim comparison.
    typedef enum logic [1:0] {
        PRI_MATCH = 2'd0,
        PRI_FREE  = 2'd1,
        PRI_USED  = 2'd2
    } victim_pri_e;

    // Smallest n such that 2**n >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_entry_set_if.sv
// Lookup and refill handshake between L1 lookup logic / refill engine and the entry set.
interface cache_entry_set_if
    import cache_pkg::*;
#(
    parameter int unsigned PA_WIDTH  = PA_WIDTH_DEF,
    parameter int unsigned IDX_WIDTH = 2
);

    logic                 lookup_valid;
    logic [PA_WIDTH-1:0]  lookup_pa;
    logic                 hit_valid;
    logic                 hit;
    logic [IDX_WIDTH-1:0] hit_index;
    logic [PA_WIDTH-1:0]  hit_pa;
    logic                 fill_valid;
    logic                 fill_ready;
    logic [PA_WIDTH-1:0]  fill_pa;
    logic [IDX_WIDTH-1:0] fill_index;

    modport master (
        output lookup_valid, lookup_pa, fill_valid, fill_pa,
        input  hit_valid, hit, hit_index, hit_pa, fill_ready, fill_index
    );

    modport slave (
        input  lookup_valid, lookup_pa, fill_valid, fill_pa,
        output hit_valid, hit, hit_index, hit_pa, fill_ready, fill_index
    );

endinterface

// File: rtl/cache_victim_sel.sv
// Refill slot selector: dedupe match, else lowest invalid, else least-accessed (lowest index on tie).
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int unsigned ENTRIES   = ENTRIES_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic [ENTRIES-1:0]           valid,
    input  logic [ENTRIES*CNT_WIDTH-1:0] counts,
    input  logic [ENTRIES-1:0]           match,
    output logic [clog2(ENTRIES)-1:0]    fill_index
);

    localparam int unsigned IDX_WIDTH = clog2(ENTRIES);
    localparam int unsigned KEY_W     = 2 + CNT_WIDTH;

    // Key = {priority class, count}; count only matters among used entries.
    logic [KEY_W-1:0]     key_t [IDX_WIDTH+1][ENTRIES];
    logic [IDX_WIDTH-1:0] idx_t [IDX_WIDTH+1][ENTRIES];

    // Binary min-reduction tree; the left (lower index) operand wins ties.
    always_comb begin
        for (int l = 0; l <= int'(IDX_WIDTH); l++) begin
            for (int n = 0; n < int'(ENTRIES); n++) begin
                key_t[l][n] = '0;
                idx_t[l][n] = '0;
            end
        end
        for (int n = 0; n < int'(ENTRIES); n++) begin
            if (match[n]) begin
                key_t[0][n] = {PRI_MATCH, CNT_WIDTH'(0)};
            end else if (!valid[n]) begin
                key_t[0][n] = {PRI_FREE, CNT_WIDTH'(0)};
            end else begin
                key_t[0][n] = {PRI_USED, counts[n*CNT_WIDTH +: CNT_WIDTH]};
            end
            idx_t[0][n] = IDX_WIDTH'(n);
        end
        for (int l = 1; l <= int'(IDX_WIDTH); l++) begin
            for (int n = 0; n < int'(ENTRIES >> l); n++) begin
                if (key_t[l-1][2*n+1] < key_t[l-1][2*n]) begin
                    key_t[l][n] = key_t[l-1][2*n+1];
                    idx_t[l][n] = idx_t[l-1][2*n+1];
                end else begin
                    key_t[l][n] = key_t[l-1][2*n];
                    idx_t[l][n] = idx_t[l-1][2*n];
                end
            end
        end
        fill_index = idx_t[IDX_WIDTH][0];
    end

endmodule

// File: rtl/cache_entry_set.sv
// Fully associative tag array with registered lookup, victim-selected refill and aging access counters.
module cache_entry_set
    import cache_pkg::*;
#(
    parameter int unsigned ENTRIES     = ENTRIES_DEF,
    parameter int unsigned PA_WIDTH    = PA_WIDTH_DEF,
    parameter int unsigned OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         L1_clear,
    cache_entry_set_if.slave             bus,
    output logic [ENTRIES-1:0]           entry_valid,
    output logic [ENTRIES*CNT_WIDTH-1:0] entry_count
);

    localparam int unsigned IDX_WIDTH = clog2(ENTRIES);
    localparam int unsigned TAG_W     = PA_WIDTH - OFFSET_BITS;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_AGED = (CNT_MAX >> 1) + CNT_ONE;

    logic [TAG_W-1:0]             tag_q [ENTRIES];
    logic [TAG_W-1:0]             tag_d [ENTRIES];
    logic [CNT_WIDTH-1:0]         cnt_q [ENTRIES];
    logic [CNT_WIDTH-1:0]         cnt_d [ENTRIES];
    logic [ENTRIES-1:0]           valid_q;
    logic [ENTRIES-1:0]           valid_d;
    logic [ENTRIES*CNT_WIDTH-1:0] cnt_flat;

    logic [TAG_W-1:0]     lk_tag;
    logic [TAG_W-1:0]     fl_tag;
    logic [ENTRIES-1:0]   lk_match;
    logic [ENTRIES-1:0]   fl_match;
    logic                 lk_hit;
    logic [IDX_WIDTH-1:0] lk_idx;
    logic [IDX_WIDTH-1:0] vic_idx;
    logic                 age;
    logic                 fill_en;
    logic                 unused_offset_bits;

    assign lk_tag  = bus.lookup_pa[PA_WIDTH-1:OFFSET_BITS];
    assign fl_tag  = bus.fill_pa[PA_WIDTH-1:OFFSET_BITS];
    assign unused_offset_bits = ^{bus.lookup_pa[OFFSET_BITS-1:0], bus.fill_pa[OFFSET_BITS-1:0]};

    // Tag compare against valid entries; at most one match thanks to fill dedupe.
    always_comb begin
        lk_match = '0;
        fl_match = '0;
        lk_idx   = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            lk_match[i] = valid_q[i] && (tag_q[i] == lk_tag);
            fl_match[i] = valid_q[i] && (tag_q[i] == fl_tag);
            if (lk_match[i]) begin
                lk_idx = lk_idx | IDX_WIDTH'(i);
            end
        end
        lk_hit = |lk_match;
    end

    // Hitting a saturated counter halves every counter instead of wrapping.
    assign age     = bus.lookup_valid && lk_hit && (cnt_q[lk_idx] == CNT_MAX);
    assign fill_en = bus.fill_valid && !L1_clear;

    // Flatten counters for the selector and the status output.
    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            cnt_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    cache_victim_sel #(
        .ENTRIES   (ENTRIES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_victim_sel (
        .valid      (valid_q),
        .counts     (cnt_flat),
        .match      (fl_match),
        .fill_index (vic_idx)
    );

    assign bus.fill_ready = !L1_clear;
    assign bus.fill_index = vic_idx;
    assign entry_valid    = valid_q;
    assign entry_count    = cnt_flat;

    // Next array state: aging, then hit increment, then fill overwrite, then clear.
    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            tag_d[i]   = tag_q[i];
            valid_d[i] = valid_q[i];
            cnt_d[i]   = cnt_q[i];
            if (age) begin
                cnt_d[i] = cnt_q[i] >> 1;
            end
            if (bus.lookup_valid && lk_match[i]) begin
                cnt_d[i] = age ? CNT_AGED : cnt_q[i] + CNT_ONE;
            end
            if (fill_en && (vic_idx == IDX_WIDTH'(i))) begin
                tag_d[i]   = fl_tag;
                valid_d[i] = 1'b1;
                cnt_d[i]   = CNT_ONE;
            end
            if (L1_clear) begin
                tag_d[i]   = '0;
                valid_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end
        end
    end

    // Array storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i] <= tag_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Lookup response register, built from pre-edge array state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.hit_valid <= 1'b0;
            bus.hit       <= 1'b0;
            bus.hit_index <= '0;
            bus.hit_pa    <= '0;
        end else begin
            bus.hit_valid <= bus.lookup_valid;
            bus.hit       <= bus.lookup_valid && lk_hit;
            bus.hit_index <= (bus.lookup_valid && lk_hit) ? lk_idx : '0;
            bus.hit_pa    <= (bus.lookup_valid && lk_hit) ? {tag_q[lk_idx], OFFSET_BITS'(0)} : '0;
        end
    end

endmodule

// File: tb/tb_cache_entry_set.sv
// Directed bench for cache_entry_set (4 entries, 4-bit counters).
module tb_cache_entry_set;

    localparam int unsigned ENTRIES     = 4;
    localparam int unsigned PA_WIDTH    = 64;
    localparam int unsigned OFFSET_BITS = 6;
    localparam int unsigned CNT_WIDTH   = 4;
    localparam int unsigned IDX_WIDTH   = 2;
    localparam int unsigned NVEC        = 14;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         L1_clear;
    logic [ENTRIES-1:0]           entry_valid;
    logic [ENTRIES*CNT_WIDTH-1:0] entry_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_entry_set_if #(.PA_WIDTH(PA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

    cache_entry_set #(
        .ENTRIES     (ENTRIES),
        .PA_WIDTH    (PA_WIDTH),
        .OFFSET_BITS (OFFSET_BITS),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .L1_clear    (L1_clear),
        .bus         (bus),
        .entry_valid (entry_valid),
        .entry_count (entry_count)
    );

    typedef struct {
        logic        clr;
        logic        lv;
        logic [63:0] lpa;
        logic        fv;
        logic [63:0] fpa;
        logic [1:0]  e_fidx;
        logic        e_hv;
        logic        e_hit;
        logic [1:0]  e_hidx;
        logic [63:0] e_hpa;
        logic [3:0]  e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [NVEC];
    logic [63:0] lines [4];

    function automatic vec_t mk(input logic clr, input logic lv, input logic [63:0] lpa,
                                input logic fv, input logic [63:0] fpa, input logic [1:0] fidx,
                                input logic hv, input logic h, input logic [1:0] hidx,
                                input logic [63:0] hpa, input logic [3:0] ev, input logic [15:0] ec);
        vec_t v;
        v.clr = clr; v.lv = lv; v.lpa = lpa; v.fv = fv; v.fpa = fpa; v.e_fidx = fidx;
        v.e_hv = hv; v.e_hit = h; v.e_hidx = hidx; v.e_hpa = hpa; v.e_valid = ev; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic lv, input logic [63:0] lpa,
                         input logic fv, input logic [63:0] fpa);
        L1_clear         = clr;
        bus.lookup_valid = lv;
        bus.lookup_pa    = lpa;
        bus.fill_valid   = fv;
        bus.fill_pa      = fpa;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic hv, input logic h,
                            input logic [1:0] hidx, input logic [63:0] hpa);
        chk({tag, ".hit_valid"}, 64'(bus.hit_valid), 64'(hv));
        chk({tag, ".hit"},       64'(bus.hit),       64'(h));
        chk({tag, ".hit_index"}, 64'(bus.hit_index), 64'(hidx));
        chk({tag, ".hit_pa"},    bus.hit_pa,         hpa);
    endtask

    task automatic chk_state(input string tag, input logic [3:0] ev, input logic [15:0] ec);
        chk({tag, ".entry_valid"}, 64'(entry_valid), 64'(ev));
        chk({tag, ".entry_count"}, 64'(entry_count), 64'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        // Counts listed as {c3,c2,c1,c0}, one hex digit each.
        vecs[0]  = mk(0, 0, 64'h0,    1, 64'h1000, 0, 0, 0, 0, 64'h0,    4'b0001, 16'h0001);
        vecs[1]  = mk(0, 1, 64'h1004, 0, 64'h0,    0, 1, 1, 0, 64'h1000, 4'b0001, 16'h0002);
        vecs[2]  = mk(0, 0, 64'h0,    1, 64'h2000, 1, 0, 0, 0, 64'h0,    4'b0011, 16'h0012);
        vecs[3]  = mk(0, 0, 64'h0,    1, 64'h3000, 2, 0, 0, 0, 64'h0,    4'b0111, 16'h0112);
        vecs[4]  = mk(0, 0, 64'h0,    1, 64'h4000, 3, 0, 0, 0, 64'h0,    4'b1111, 16'h1112);
        vecs[5]  = mk(0, 1, 64'h1000, 0, 64'h0,    0, 1, 1, 0, 64'h1000, 4'b1111, 16'h1113);
        vecs[6]  = mk(0, 1, 64'h203F, 0, 64'h0,    0, 1, 1, 1, 64'h2000, 4'b1111, 16'h1123);
        vecs[7]  = mk(0, 1, 64'h7000, 0, 64'h0,    0, 1, 0, 0, 64'h0,    4'b1111, 16'h1123);
        vecs[8]  = mk(0, 0, 64'h0,    1, 64'h5000, 2, 0, 0, 0, 64'h0,    4'b1111, 16'h1123);
        vecs[9]  = mk(0, 1, 64'h3000, 0, 64'h0,    0, 1, 0, 0, 64'h0,    4'b1111, 16'h1123);
        vecs[10] = mk(0, 1, 64'h5010, 0, 64'h0,    0, 1, 1, 2, 64'h5000, 4'b1111, 16'h1223);
        vecs[11] = mk(0, 0, 64'h0,    1, 64'h1020, 0, 0, 0, 0, 64'h0,    4'b1111, 16'h1221);
        vecs[12] = mk(0, 0, 64'h0,    0, 64'h0,    0, 0, 0, 0, 64'h0,    4'b1111, 16'h1221);
        vecs[13] = mk(0, 1, 64'h2000, 1, 64'h6000, 0, 1, 1, 1, 64'h2000, 4'b1111, 16'h1231);
        lines[0] = 64'h1000;
        lines[1] = 64'h2000;
        lines[2] = 64'h3000;
        lines[3] = 64'h4000;

        rst = 1'b0;
        drive(0, 0, 64'h0, 0, 64'h0);
        #2;
        chk_resp("reset", 0, 0, 0, 64'h0);
        chk_state("reset", 4'b0000, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].clr, vecs[i].lv, vecs[i].lpa, vecs[i].fv, vecs[i].fpa);
            #1;
            chk($sformatf("v%0d.fill_ready", i), 64'(bus.fill_ready), 64'(!vecs[i].clr));
            if (vecs[i].fv) begin
                chk($sformatf("v%0d.fill_index", i), 64'(bus.fill_index), 64'(vecs[i].e_fidx));
            end
            tick();
            chk_resp($sformatf("v%0d", i), vecs[i].e_hv, vecs[i].e_hit, vecs[i].e_hidx, vecs[i].e_hpa);
            chk_state($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_cnt);
        end

        // Saturation: drive entry 0 to 15 and entry 1 to 6, then hit entry 0 once more.
        for (int k = 0; k < 14; k++) begin
            drive(0, 1, 64'h6000, 0, 64'h0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 64'h2000, 0, 64'h0);
            tick();
        end
        chk_state("sat_pre", 4'b1111, 16'h126F);
        drive(0, 1, 64'h6008, 0, 64'h0);
        tick();
        chk_resp("sat_hit", 1, 1, 0, 64'h6000);
        chk_state("sat_age", 4'b1111, 16'h0138);

        // Clear with a simultaneous fill and a hitting lookup.
        drive(1, 1, 64'h4000, 1, 64'h9000);
        #1;
        chk("clr.fill_ready", 64'(bus.fill_ready), 64'h0);
        tick();
        chk_resp("clr", 1, 1, 3, 64'h4000);
        chk_state("clr", 4'b0000, 16'h0000);
        drive(0, 1, 64'h4000, 0, 64'h0);
        tick();
        chk_resp("post_clr", 1, 0, 0, 64'h0);

        // Same-cycle hit and fill on entry 2.
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 64'h0, 1, lines[k]);
            tick();
        end
        drive(0, 1, 64'h1000, 0, 64'h0); tick();
        drive(0, 1, 64'h2000, 0, 64'h0); tick();
        drive(0, 1, 64'h4000, 0, 64'h0); tick();
        chk_state("same_pre", 4'b1111, 16'h2122);
        drive(0, 1, 64'h3000, 1, 64'h8000);
        #1;
        chk("same.fill_index", 64'(bus.fill_index), 64'h2);
        tick();
        chk_resp("same", 1, 1, 2, 64'h3000);
        chk_state("same", 4'b1111, 16'h2122);
        drive(0, 1, 64'h8000, 0, 64'h0);
        tick();
        chk_resp("same_new", 1, 1, 2, 64'h8000);
        chk_state("same_new", 4'b1111, 16'h2222);
        drive(0, 1, 64'h3000, 0, 64'h0);
        tick();
        chk_resp("same_old", 1, 0, 0, 64'h0);

        // Asynchronous reset while a response is being presented.
        drive(0, 1, 64'h8000, 0, 64'h0);
        tick();
        chk("rst_pre.hit_valid", 64'(bus.hit_valid), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        chk_resp("rst_async", 0, 0, 0, 64'h0);
        chk_state("rst_async", 4'b0000, 16'h0000);
        drive(0, 0, 64'h0, 0, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 64'h8000, 0, 64'h0);
        tick();
        chk_resp("rst_after", 1, 0, 0, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
